spi_sram_target_sync: RTL and testbench



---
 rtl/spi_sram_target_sync.sv | 266 ++++++++++++++++++++++++++
 tb/tb_spi_sram_target_sync.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sram_target_sync.sv
// SPI mode-0 SRAM target, oversampled in the clk domain, decoding 23LC-style
// READ/WRITE/RDMR/WRMR commands onto a registered single-port memory interface.
module spi_sram_target_sync #(
  parameter int          SYNC_STAGES = 2,
  parameter int          ADDR_BYTES  = 3,
  parameter logic [7:0]  MODE_RESET  = 8'h40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic [23:0] mem_addr,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam logic [4:0]  ADDR_LAST = 5'(ADDR_BYTES * 8 - 1);
  localparam logic [23:0] ADDR_MASK = (ADDR_BYTES == 2) ? 24'h00FFFF : 24'hFFFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_READ,
    S_WRITE,
    S_RDMODE,
    S_WRMODE,
    S_IGNORE
  } state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sck_sync_reg;
  logic [SYNC_STAGES-1:0] cs_sync_reg;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic [SYNC_STAGES-1:0] warm_reg;

  logic        armed_reg;
  logic [4:0]  bit_cnt_reg;
  logic [6:0]  shift_reg;
  logic [23:0] addr_reg;
  logic        is_read_reg;
  logic        first_reg;
  logic        rd_cap_reg;
  logic [7:0]  tx_reg;
  logic [7:0]  pf_reg;
  logic [3:0]  tx_cnt_reg;
  logic [7:0]  mode_reg;
  logic        miso_reg;
  logic [23:0] mem_addr_reg;
  logic        mem_en_reg;
  logic        mem_wr_reg;
  logic [7:0]  mem_wdata_reg;

  logic        sck_rise;
  logic        sck_fall;
  logic        cs_high;
  logic        mosi_s;
  logic [7:0]  rx_byte;
  logic [23:0] addr_full;
  logic [23:0] addr_inc;

  // Bit 0 is the newest sample; edges compare the last stage with the one before it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_reg  <= '0;
      cs_sync_reg   <= '1;
      mosi_sync_reg <= '0;
      warm_reg      <= '0;
    end else begin
      sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], sck};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], cs_n};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
      warm_reg      <= {warm_reg[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sck_rise  = sck_sync_reg[SYNC_STAGES-2] & ~sck_sync_reg[SYNC_STAGES-1];
  assign sck_fall  = ~sck_sync_reg[SYNC_STAGES-2] & sck_sync_reg[SYNC_STAGES-1];
  assign cs_high   = cs_sync_reg[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
  assign rx_byte   = {shift_reg, mosi_s};
  assign addr_full = {addr_reg[22:0], mosi_s} & ADDR_MASK;
  assign addr_inc  = (addr_reg + 24'd1) & ADDR_MASK;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (cs_high) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          // After reset, a select that was already low is not a valid start.
          if (armed_reg) state_next = S_CMD;
        end
        S_CMD: begin
          if (sck_rise && bit_cnt_reg == 5'd7) begin
            case (rx_byte)
              8'h03, 8'h02: state_next = S_ADDR;
              8'h05:        state_next = S_RDMODE;
              8'h01:        state_next = S_WRMODE;
              default:      state_next = S_IGNORE;
            endcase
          end
        end
        S_ADDR: begin
          if (sck_rise && bit_cnt_reg == ADDR_LAST) begin
            state_next = is_read_reg ? S_READ : S_WRITE;
          end
        end
        S_WRMODE: begin
          if (sck_rise && bit_cnt_reg == 5'd7) state_next = S_IGNORE;
        end
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_reg     <= 1'b0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      addr_reg      <= '0;
      is_read_reg   <= 1'b0;
      first_reg     <= 1'b1;
      rd_cap_reg    <= 1'b0;
      tx_reg        <= '0;
      pf_reg        <= '0;
      tx_cnt_reg    <= '0;
      mode_reg      <= MODE_RESET;
      miso_reg      <= 1'b0;
      mem_addr_reg  <= '0;
      mem_en_reg    <= 1'b0;
      mem_wr_reg    <= 1'b0;
      mem_wdata_reg <= '0;
    end else begin
      mem_en_reg <= 1'b0;
      mem_wr_reg <= 1'b0;
      // Read data is valid the cycle after the memory samples the strobe.
      rd_cap_reg <= mem_en_reg & ~mem_wr_reg;
      if (cs_high && warm_reg[SYNC_STAGES-1]) armed_reg <= 1'b1;

      if (cs_high) begin
        bit_cnt_reg <= '0;
        shift_reg   <= '0;
        tx_cnt_reg  <= '0;
        miso_reg    <= 1'b0;
      end else begin
        case (state_reg)
          S_CMD: begin
            if (sck_rise) begin
              shift_reg <= rx_byte[6:0];
              if (bit_cnt_reg == 5'd7) begin
                bit_cnt_reg <= '0;
                is_read_reg <= (rx_byte == 8'h03);
                first_reg   <= 1'b1;
                addr_reg    <= '0;
                tx_cnt_reg  <= '0;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 5'd1;
              end
            end
          end
          S_ADDR: begin
            if (sck_rise) begin
              addr_reg <= addr_full;
              if (bit_cnt_reg == ADDR_LAST) begin
                bit_cnt_reg <= '0;
                if (is_read_reg) begin
                  mem_en_reg   <= 1'b1;
                  mem_addr_reg <= addr_full;
                end
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 5'd1;
              end
            end
          end
          S_READ: begin
            if (rd_cap_reg) begin
              if (first_reg) begin
                tx_reg       <= mem_rdata;
                first_reg    <= 1'b0;
                addr_reg     <= addr_inc;
                mem_en_reg   <= 1'b1;
                mem_addr_reg <= addr_inc;
              end else begin
                pf_reg <= mem_rdata;
              end
            end
            if (sck_fall) begin
              if (tx_cnt_reg == 4'd8) begin
                // Byte boundary: swap in the prefetched byte and fetch the next one.
                miso_reg     <= pf_reg[7];
                tx_reg       <= {pf_reg[6:0], 1'b0};
                tx_cnt_reg   <= 4'd1;
                addr_reg     <= addr_inc;
                mem_en_reg   <= 1'b1;
                mem_addr_reg <= addr_inc;
              end else begin
                miso_reg   <= tx_reg[7];
                tx_reg     <= {tx_reg[6:0], 1'b0};
                tx_cnt_reg <= tx_cnt_reg + 4'd1;
              end
            end
          end
          S_WRITE: begin
            if (sck_rise) begin
              shift_reg <= rx_byte[6:0];
              if (bit_cnt_reg == 5'd7) begin
                bit_cnt_reg   <= '0;
                mem_en_reg    <= 1'b1;
                mem_wr_reg    <= 1'b1;
                mem_wdata_reg <= rx_byte;
                mem_addr_reg  <= addr_reg;
                addr_reg      <= addr_inc;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 5'd1;
              end
            end
          end
          S_RDMODE: begin
            if (sck_fall) begin
              miso_reg   <= mode_reg[~tx_cnt_reg[2:0]];
              tx_cnt_reg <= {1'b0, tx_cnt_reg[2:0] + 3'd1};
            end
          end
          S_WRMODE: begin
            if (sck_rise) begin
              shift_reg <= rx_byte[6:0];
              if (bit_cnt_reg == 5'd7) begin
                bit_cnt_reg <= '0;
                mode_reg    <= rx_byte;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 5'd1;
              end
            end
          end
          default: begin
            bit_cnt_reg <= '0;
            miso_reg    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign miso      = miso_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_en    = mem_en_reg;
  assign mem_wr    = mem_wr_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_spi_sram_target_sync.sv
// Directed bench for spi_sram_target_sync: bit-banged SPI master, registered
// memory models and scoreboard queues for strobes and returned bytes.
module tb_spi_sram_target_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sck, cs_n, cs2_n, mosi, sel2;
  logic        miso, miso2;
  logic [23:0] mem_addr, mem_addr2;
  logic        mem_en, mem_wr, mem_en2, mem_wr2;
  logic [7:0]  mem_wdata, mem_wdata2;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  mem_rdata2 = 8'h00;

  spi_sram_target_sync #(.SYNC_STAGES(2), .ADDR_BYTES(3), .MODE_RESET(8'h40)) dut (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  spi_sram_target_sync #(.SYNC_STAGES(2), .ADDR_BYTES(2), .MODE_RESET(8'h40)) dut2 (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(cs2_n), .mosi(mosi), .miso(miso2),
    .mem_addr(mem_addr2), .mem_en(mem_en2), .mem_wr(mem_wr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
  );

  int n_assert = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Registered memories: read data appears the clk after the strobe is sampled.
  logic [7:0] mem1 [logic [23:0]];
  logic [7:0] mem2 [logic [23:0]];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr) mem1[mem_addr] = mem_wdata;
      else mem_rdata <= mem1.exists(mem_addr) ? mem1[mem_addr] : 8'h00;
    end
    if (mem_en2) begin
      if (mem_wr2) mem2[mem_addr2] = mem_wdata2;
      else mem_rdata2 <= mem2.exists(mem_addr2) ? mem2[mem_addr2] : 8'h00;
    end
  end

  logic [23:0] exp_rd_q[$];
  logic [31:0] exp_wr_q[$];
  logic [7:0]  exp_rx_q[$];
  logic [23:0] got_rd2[$];
  int wr_seen = 0;
  int rd_seen = 0;
  int wr2_seen = 0;

  always @(negedge clk) begin
    if (mem_en) begin
      if (mem_wr) begin
        wr_seen++;
        if (exp_wr_q.size() > 0) check("wr_strobe", {mem_addr, mem_wdata}, exp_wr_q.pop_front());
        else check("spurious_wr", 32'(mem_en), 32'd0);
      end else begin
        rd_seen++;
        if (exp_rd_q.size() > 0) check("rd_strobe_addr", 32'(mem_addr), 32'(exp_rd_q.pop_front()));
        else check("spurious_rd", 32'(mem_en), 32'd0);
      end
    end
    if (mem_en2) begin
      if (mem_wr2) wr2_seen++;
      else got_rd2.push_back(mem_addr2);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      wait_clk(6);
      rx[i] = sel2 ? miso2 : miso;
      sck = 1'b1;
      wait_clk(6);
      sck = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] rx;
    spi_xfer(b, 8, rx);
  endtask

  task automatic recv_check(input string tag, input logic [7:0] exp);
    logic [7:0] rx;
    exp_rx_q.push_back(exp);
    spi_xfer(8'h00, 8, rx);
    check(tag, 32'(rx), 32'(exp_rx_q.pop_front()));
  endtask

  task automatic cs_begin();
    if (sel2) cs2_n = 1'b0;
    else cs_n = 1'b0;
    wait_clk(6);
  endtask

  task automatic cs_end();
    wait_clk(6);
    cs_n = 1'b1;
    cs2_n = 1'b1;
    mosi = 1'b0;
    wait_clk(8);
  endtask

  task automatic check_reset_outputs(input string ph);
    check({ph, "_miso"}, 32'(miso), 32'd0);
    check({ph, "_mem_en"}, 32'(mem_en), 32'd0);
    check({ph, "_mem_wr"}, 32'(mem_wr), 32'd0);
    check({ph, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({ph, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  initial begin
    logic [7:0] rx;
    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; cs2_n = 1'b1; mosi = 1'b0; sel2 = 1'b0;
    wait_clk(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_clk(6);

    // Two-byte sequential write at 0x000200.
    exp_wr_q.push_back({24'h000200, 8'hAA});
    exp_wr_q.push_back({24'h000201, 8'h55});
    cs_begin();
    send(8'h02); send(8'h00); send(8'h02); send(8'h00); send(8'hAA); send(8'h55);
    cs_end();
    check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    check("mem_000200", 32'(mem1[24'h000200]), 32'h0000_00AA);
    check("mem_000201", 32'(mem1[24'h000201]), 32'h0000_0055);
    check("write_strobes", 32'(wr_seen), 32'd2);
    check("no_read_strobes", 32'(rd_seen), 32'd0);

    // Sequential read wrapping from 0xFFFFFF; the fall after bit 16 loads a
    // third byte and prefetches 0x000002.
    mem1[24'hFFFFFF] = 8'h12;
    mem1[24'h000000] = 8'h34;
    mem1[24'h000001] = 8'h56;
    exp_rd_q.push_back(24'hFFFFFF);
    exp_rd_q.push_back(24'h000000);
    exp_rd_q.push_back(24'h000001);
    exp_rd_q.push_back(24'h000002);
    cs_begin();
    send(8'h03); send(8'hFF); send(8'hFF); send(8'hFF);
    recv_check("read_byte0", 8'h12);
    recv_check("read_byte1", 8'h34);
    cs_end();
    check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
    check("read_strobes", 32'(rd_seen), 32'd4);

    // Mode register: reset value, then written to 0x00 and read back twice.
    cs_begin(); send(8'h05); recv_check("rdmr_reset", 8'h40); cs_end();
    cs_begin(); send(8'h01); send(8'h00); cs_end();
    cs_begin(); send(8'h05); recv_check("rdmr_new0", 8'h00); recv_check("rdmr_new1", 8'h00); cs_end();

    // Unknown command returns zeros and never strobes.
    cs_begin(); send(8'h9F); recv_check("ignore_byte0", 8'h00); recv_check("ignore_byte1", 8'h00); cs_end();

    // Partial data byte aborted by cs_n high must not write.
    cs_begin();
    send(8'h02); send(8'h00); send(8'h01); send(8'h00);
    spi_xfer(8'hFF, 5, rx);
    cs_end();
    check("abort_no_write", 32'(wr_seen), 32'd2);
    exp_wr_q.push_back({24'h000100, 8'hC3});
    cs_begin(); send(8'h02); send(8'h00); send(8'h01); send(8'h00); send(8'hC3); cs_end();
    check("mem_000100", 32'(mem1[24'h000100]), 32'h0000_00C3);
    check("write_after_abort", 32'(wr_seen), 32'd3);

    // Two-byte address instance.
    mem2[24'h001234] = 8'h5A;
    sel2 = 1'b1;
    cs_begin(); send(8'h03); send(8'h12); send(8'h34); recv_check("addr2_read", 8'h5A); cs_end();
    sel2 = 1'b0;
    check("addr2_first_rd", 32'(got_rd2.size() > 0 ? got_rd2[0] : 24'hxxxxxx), 32'h0000_1234);
    check("addr2_prefetch", 32'(got_rd2.size() > 1 ? got_rd2[1] : 24'hxxxxxx), 32'h0000_1235);
    check("addr2_no_write", 32'(wr2_seen), 32'd0);

    // Reset in the middle of a read, with cs_n still low.
    mem1[24'h000010] = 8'h9C;
    mem1[24'h000011] = 8'hA5;
    exp_rd_q.push_back(24'h000010);
    exp_rd_q.push_back(24'h000011);
    cs_begin();
    send(8'h03); send(8'h00); send(8'h00); send(8'h10);
    spi_xfer(8'h00, 4, rx);
    rst = 1'b1;
    wait_clk(1);
    check_reset_outputs("midrst_a");
    wait_clk(2);
    check_reset_outputs("midrst_b");
    rst = 1'b0;
    wait_clk(4);
    // Still selected since before reset: this command must be ignored.
    send(8'h03); send(8'h00); send(8'h00); send(8'h10);
    recv_check("post_reset_ignored", 8'h00);
    cs_end();
    check("post_reset_no_strobe", 32'(rd_seen), 32'd6);
    exp_rd_q.push_back(24'h000010);
    exp_rd_q.push_back(24'h000011);
    exp_rd_q.push_back(24'h000012);
    cs_begin(); send(8'h03); send(8'h00); send(8'h00); send(8'h10); recv_check("fresh_read", 8'h9C); cs_end();
    check("final_rd_queue", 32'(exp_rd_q.size()), 32'd0);
    check("final_wr_queue", 32'(exp_wr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
